// File: rtl/instruction_loader_pkg.sv
// Shared constants and types for the run-time instruction memory loader.
// The CPU top level reuses HALT_WORD as its out-of-range fetch value.
package instruction_loader_pkg;

  localparam int          DEPTH     = 256;
  localparam int          ADDR_W    = 8;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    FILL,
    DONE,
    ERR
  } state_t;

  // Byte of a big-endian word that lands at an address with the given low bits.
  function automatic logic [7:0] halt_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Streams a checksummed program image into instruction memory, pads the rest
// with the halt word, and keeps the CPU held until the image is complete.
module instruction_loader #(
  parameter int          DEPTH     = instruction_loader_pkg::DEPTH,
  parameter int          ADDR_W    = instruction_loader_pkg::ADDR_W,
  parameter logic [31:0] HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  import instruction_loader_pkg::*;

  // One extra bit so a full image (count == DEPTH) is representable without wrap.
  typedef logic [ADDR_W:0] cnt_t;

  state_t     state;
  cnt_t       count;
  cnt_t       total;
  logic [7:0] xor_acc;
  logic       xfer;
  logic       hdr_bad;

  assign in_ready = (state == HDR) || (state == DATA) || (state == CSUM);
  assign xfer     = in_valid && in_ready;
  assign hdr_bad  = (in_byte == 8'd0) || (int'(in_byte) > DEPTH / 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      total     <= '0;
      xor_acc   <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // NOTE: all state here is non-blocking; mem_write defaults low each cycle
      // and a later assignment in the same branch overrides the default.
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              total   <= cnt_t'(in_byte) << 2;
              count   <= '0;
              xor_acc <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            mem_write <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_data  <= in_byte;
            xor_acc   <= xor_acc ^ in_byte;
            count     <= count + cnt_t'(1);
            if (count == total - cnt_t'(1)) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (in_byte != xor_acc) begin
              state <= ERR;
              error <= 1'b1;
            end else if (total == cnt_t'(DEPTH)) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // First pad write goes out alongside the FILL entry, saving a cycle.
              state     <= FILL;
              mem_write <= 1'b1;
              mem_addr  <= total[ADDR_W-1:0];
              mem_data  <= halt_byte(HALT_WORD, total[1:0]);
              count     <= total + cnt_t'(1);
            end
          end
        end
        FILL: begin
          if (count == cnt_t'(DEPTH)) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            mem_write <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_data  <= halt_byte(HALT_WORD, count[1:0]);
            count     <= count + cnt_t'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboarded bench for instruction_loader: a table of load sessions plus
// hand-written reset-abort and Start-while-busy sequences.
module tb_instruction_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_byte = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       done;
  logic       error;

  instruction_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    string name;
    int    w;
    bit    preset;
    bit    bad;
    int    gap;
  } sess_t;

  wr_t        exp_q[$];
  wr_t        got_e;
  logic [7:0] img[256];
  sess_t      tbl[7];
  sess_t      hand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] halt_of(input int a);
    return (a % 4 == 0) ? 8'hFC : 8'h00;
  endfunction

  // Every write the DUT issues must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_write), 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), got_e.addr);
        check("wr_data", 32'(mem_data), 32'(got_e.data));
        check("wr_cycle", cyc, got_e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d pending writes", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic do_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_start_done"}, 32'(done), 32'd0);
    check({name, "_start_error"}, 32'(error), 32'd0);
    check({name, "_start_hold"}, 32'(cpu_hold), 32'd1);
    check({name, "_start_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Offers one byte (with random idle gaps) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input int addr, input int gap);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_byte  = b;
        if (in_ready) begin
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          if (is_data) exp_q.push_back('{addr, b, cyc});
          return;
        end
      end
    end
    check("send_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_session(input sess_t s);
    int         k;
    int         nfill;
    bit         valid;
    bit         ok;
    logic [7:0] csum;
    do_start(s.name);
    send_byte(8'(s.w), 1'b0, 0, s.gap);
    k     = cyc;
    nfill = 0;
    valid = (s.w >= 1) && (s.w <= 64);
    ok    = valid && !s.bad;
    if (valid) begin
      csum = 8'd0;
      for (int i = 0; i < 4 * s.w; i++) begin
        if (!s.preset) img[i] = 8'($urandom);
        csum ^= img[i];
      end
      for (int i = 0; i < 4 * s.w; i++) send_byte(img[i], 1'b1, i, s.gap);
      send_byte(s.bad ? 8'h00 : csum, 1'b0, 0, s.gap);
      k = cyc;
      if (ok) begin
        for (int a = 4 * s.w; a < 256; a++) begin
          exp_q.push_back('{a, halt_of(a), k + nfill});
          nfill++;
        end
      end
    end
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (done || error) break;
    end
    check({s.name, "_end_cycle"}, cyc, k + nfill);
    check({s.name, "_done"}, 32'(done), 32'(ok));
    check({s.name, "_error"}, 32'(error), 32'(!ok));
    check({s.name, "_hold"}, 32'(cpu_hold), 32'(!ok));
    check({s.name, "_ready"}, 32'(in_ready), 32'd0);
    check({s.name, "_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
    check({name, "_write"}, 32'(mem_write), 32'd0);
    check({name, "_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_data"}, 32'(mem_data), 32'd0);
    check({name, "_hold"}, 32'(cpu_hold), 32'd1);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    img[0] = 8'h20; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h05;
    img[4] = 8'hFC; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h00;
    tbl[0] = '{"w2_fixed",   2,  1'b1, 1'b0, 0};
    tbl[1] = '{"w2_badcsum", 2,  1'b1, 1'b1, 0};
    tbl[2] = '{"w0",         0,  1'b0, 1'b0, 0};
    tbl[3] = '{"w65",        65, 1'b0, 1'b0, 0};
    tbl[4] = '{"w1",         1,  1'b0, 1'b0, 0};
    tbl[5] = '{"w64_gaps",   64, 1'b0, 1'b0, 50};
    tbl[6] = '{"w63",        63, 1'b0, 1'b0, 25};

    #1 rst_n = 1'b0;
    #2;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_hold", 32'(cpu_hold), 32'd1);

    for (int i = 0; i < 7; i++) run_session(tbl[i]);

    // Abort mid-DATA: three bytes of a W=4 image, then an asynchronous reset.
    do_start("rst");
    send_byte(8'd4, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      img[i] = 8'($urandom);
      send_byte(img[i], 1'b1, i, 0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    check("mid_rst_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hand = '{"w4_after_rst", 4, 1'b0, 1'b0, 0};
    run_session(hand);

    // Start pulses while busy must not disturb the session in progress.
    hand = '{"w3_start_in_data", 3, 1'b0, 1'b0, 0};
    fork
      run_session(hand);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    hand = '{"w3_start_in_fill", 3, 1'b0, 1'b0, 0};
    fork
      run_session(hand);
      begin
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
